// File: rtl/led_mode_sequencer_if.sv
// Start/done handshake between the LED mode sequencer and the pattern engine.
// master: sequencer side, slave: pattern engine side.
interface led_mode_sequencer_if;
    logic       start_o;
    logic [1:0] mode_o;
    logic       busy_o;
    logic       timeout_err_o;
    logic       done_i;

    modport master (
        output start_o,
        output mode_o,
        output busy_o,
        output timeout_err_o,
        input  done_i
    );

    modport slave (
        input  start_o,
        input  mode_o,
        input  busy_o,
        input  timeout_err_o,
        output done_i
    );
endinterface

// File: rtl/led_mode_sequencer.sv
// Debounces the board keys, decodes a display mode and sequences the pattern engine.
// Optional LED_SEQ_AUTO_CYCLE_EN: after each gap, advance to the next mode automatically.
module led_mode_sequencer #(
    parameter int unsigned p_frequency   = 50_000_000,
    parameter int unsigned p_debounce_ms = 20,
    parameter int unsigned p_pwm_run_ms  = 5,
    parameter int unsigned p_timeout_ms  = 1000,
    parameter int unsigned p_gap_cycles  = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_2,
    input  logic                        key_3,
    input  logic                        key_4,
    led_mode_sequencer_if.master        eng_if
);
    localparam int unsigned c_ms      = p_frequency / 1000;
    localparam int unsigned c_db_lim  = p_debounce_ms * c_ms;
    localparam int unsigned c_pwm_lim = p_pwm_run_ms * c_ms;
    localparam int unsigned c_to_lim  = p_timeout_ms * c_ms;
    localparam int unsigned c_run_lim = (c_to_lim > c_pwm_lim) ? c_to_lim : c_pwm_lim;

    localparam int unsigned c_db_w  = (c_db_lim > 1) ? $clog2(c_db_lim) : 1;
    localparam int unsigned c_run_w = (c_run_lim > 1) ? $clog2(c_run_lim) : 1;
    localparam int unsigned c_gap_w = (p_gap_cycles > 1) ? $clog2(p_gap_cycles) : 1;

    localparam logic [c_db_w-1:0]  c_db_last  = c_db_w'(c_db_lim - 1);
    localparam logic [c_run_w-1:0] c_to_last  = c_run_w'(c_to_lim - 1);
    localparam logic [c_run_w-1:0] c_pwm_last = c_run_w'(c_pwm_lim - 1);
    localparam logic [c_run_w-1:0] c_run_last = c_run_w'(c_run_lim - 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(p_gap_cycles - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_PWM  = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [2:0]         r_sync1, r_sync2;
    logic [2:0]         r_cand, r_db;
    logic [c_db_w-1:0]  r_db_cnt;
    logic               r_pend_vld;
    logic [1:0]         r_pend_mode;
    logic [2:0]         r_state;
    logic [1:0]         r_mode;
    logic               r_err;
    logic [c_run_w-1:0] r_run_cnt;
    logic [c_gap_w-1:0] r_gap_cnt;

    logic [2:0] w_p;
    logic       w_press;
    logic       w_dec_vld;
    logic [1:0] w_dec_mode;
    logic       w_pend_wr;
    logic [2:0] w_state_nxt;
    logic       w_take;
    logic       w_load;
    logic [1:0] w_load_mode;
    logic       w_err_set;

    // Keys idle high, so the synchronisers reset to "released".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 3'b111;
            r_sync2 <= 3'b111;
        end else begin
            r_sync1 <= {key_4, key_3, key_2};
            r_sync2 <= r_sync1;
        end
    end

    assign w_p     = ~r_sync2;
    assign w_press = (w_p == r_cand) && (r_db_cnt == c_db_last) &&
                     (r_db == 3'b000) && (r_cand != 3'b000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand   <= 3'b000;
            r_db     <= 3'b000;
            r_db_cnt <= '0;
        end else if (w_p != r_cand) begin
            r_cand   <= w_p;
            r_db_cnt <= '0;
        end else if (r_db_cnt != c_db_last) begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end else begin
            r_db     <= r_cand;
        end
    end

    always_comb begin
        w_dec_vld  = 1'b1;
        w_dec_mode = 2'd0;
        case (r_cand)
            3'b001:  w_dec_mode = 2'd0;
            3'b010:  w_dec_mode = 2'd1;
            3'b100:  w_dec_mode = 2'd2;
            3'b011:  w_dec_mode = 2'd3;
            default: w_dec_vld  = 1'b0;
        endcase
    end

    assign w_pend_wr = w_press && w_dec_vld;

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_load      = 1'b0;
        w_load_mode = r_pend_mode;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_vld) begin
                    w_take      = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: w_state_nxt = (r_mode == 2'd3) ? S_PWM : S_RUN;
            S_RUN: begin
                // done wins over a timeout landing on the same cycle
                if (eng_if.done_i) begin
                    w_state_nxt = S_GAP;
                end else if (r_run_cnt == c_to_last) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_PWM: begin
                if (r_pend_vld || (r_run_cnt == c_pwm_last)) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == c_gap_last) begin
`ifdef LED_SEQ_AUTO_CYCLE_EN
                    w_state_nxt = S_ARM;
                    w_load      = 1'b1;
                    if (r_pend_vld) begin
                        w_take = 1'b1;
                    end else begin
                        w_load_mode = r_mode + 2'd1;
                    end
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'd0;
            r_err       <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_mode <= 2'd0;
            r_run_cnt   <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_mode <= w_load_mode;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (r_state == S_ARM) begin
                r_err <= 1'b0;
            end
            // A fresh press always beats consumption of the older entry.
            if (w_pend_wr) begin
                r_pend_vld  <= 1'b1;
                r_pend_mode <= w_dec_mode;
            end else if (w_take) begin
                r_pend_vld  <= 1'b0;
            end
            // The start cycle itself counts as the first cycle of the run.
            if (r_state == S_ARM) begin
                r_run_cnt <= c_run_w'(1);
            end else if (((r_state == S_RUN) || (r_state == S_PWM)) &&
                         (r_run_cnt != c_run_last)) begin
                r_run_cnt <= r_run_cnt + 1'b1;
            end
            if (r_state != S_GAP) begin
                r_gap_cnt <= '0;
            end else if (r_gap_cnt != c_gap_last) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
        end
    end

    assign eng_if.start_o       = (r_state == S_ARM);
    assign eng_if.busy_o        = (r_state != S_IDLE);
    assign eng_if.mode_o        = r_mode;
    assign eng_if.timeout_err_o = r_err;
endmodule
